// File: rtl/softplus_vec_ctrl.sv
// Sequences a vector of fixed-point activations through one shared softplus unit.
// Ports: start/abort/len/src_base/dst_base in; busy/done/aborted, rd_*, sp_x/sp_y, wr_*, clamp_cnt.
module softplus_vec_ctrl #(
  parameter int N      = 16,
  parameter int Q      = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N-1:0]      sp_x,
  input  logic [N-1:0]      sp_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic [ADDR_W-1:0] clamp_cnt
);

  typedef enum logic [2:0] {
    IDLE, RD, LAT, EVAL, WR, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] idx;

  // Q is the binary point of the data; nothing here depends on it.
  logic [N-1:0] unused_q;
  assign unused_q = N'(Q);

  // Strobes and pulses are registered: they are set on the edge that
  // enters the state in which they must be visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      sp_x      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      clamp_cnt <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            src_q     <= src_base;
            dst_q     <= dst_base;
            idx       <= '0;
            clamp_cnt <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RD;
              rd_en   <= 1'b1;
              rd_addr <= src_base;
            end
          end
        end
        RD: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state <= LAT;
          end
        end
        LAT: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            sp_x  <= rd_data;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            // A negative softplus result can only be a unit fault.
            if (sp_y[N-1]) begin
              wr_data   <= '0;
              clamp_cnt <= clamp_cnt + ADDR_W'(1);
            end else begin
              wr_data <= sp_y;
            end
            wr_en   <= 1'b1;
            wr_addr <= dst_q + idx;
            state   <= WR;
          end
        end
        WR: begin
          idx <= idx + ADDR_W'(1);
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (idx + ADDR_W'(1) == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= RD;
            rd_en   <= 1'b1;
            rd_addr <= src_q + idx + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softplus_vec_ctrl.sv
// Directed bench for softplus_vec_ctrl with a buffer model and a PWL softplus stub.
// Each task runs one scenario and checks its own results.
module tb_softplus_vec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  len;
  logic [7:0]  src_base;
  logic [7:0]  dst_base;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] sp_x;
  logic [15:0] sp_y;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  clamp_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [256];
  logic        neg_on = 1'b0;

  softplus_vec_ctrl #(.N(16), .Q(12), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .len(len), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .aborted(aborted),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sp_x(sp_x), .sp_y(sp_y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clamp_cnt(clamp_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // PWL stub: 0 below -4, x above 4, x/2 + ln2 in between.
  function automatic logic [15:0] sp_model(input logic [15:0] x);
    logic signed [15:0] sx;
    sx = x;
    if (sx <= -16'sh4000) return 16'h0000;
    if (sx >= 16'sh4000) return x;
    return 16'(sx >>> 1) + 16'h0B17;
  endfunction

  always_comb begin
    sp_y = sp_model(sp_x);
    if (neg_on && sp_x == 16'h7777) sp_y = 16'h8000;
  end

  int          wr_cyc[$];
  logic [7:0]  wr_a[$];
  logic [15:0] wr_d[$];
  logic [7:0]  rd_a[$];
  int          done_cyc;
  int          abort_cyc_seen;
  int          busy_n;
  int          busy_first;
  int          busy_last;
  int          overlap;
  int          extra_done;
  logic [7:0]  clamp_at_done;

  task automatic run_job(input logic [7:0] l, input logic [7:0] s,
                         input logic [7:0] d, input int ab_cyc,
                         input int restart_cyc, input int max_cyc);
    int stop_at;
    wr_cyc.delete(); wr_a.delete(); wr_d.delete(); rd_a.delete();
    done_cyc = -1; abort_cyc_seen = -1; busy_n = 0;
    busy_first = -1; busy_last = -1; overlap = 0; extra_done = 0;
    clamp_at_done = 8'hxx; stop_at = max_cyc;
    @(posedge clk); #1;
    len = l; src_base = s; dst_base = d;
    start = 1'b1; abort = (ab_cyc == 0);
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        len = 8'd7; src_base = 8'h55; dst_base = 8'h66;
      end
      abort = (c == ab_cyc);
      if (busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (rd_en && wr_en) overlap++;
      if (rd_en) rd_a.push_back(rd_addr);
      if (wr_en) begin
        wr_cyc.push_back(c); wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
      end
      if (done) begin
        if (done_cyc >= 0) extra_done++;
        else begin done_cyc = c; clamp_at_done = clamp_cnt; end
      end
      if (aborted && abort_cyc_seen < 0) abort_cyc_seen = c;
      if ((done || aborted) && stop_at == max_cyc) stop_at = c + 2;
      if (c >= stop_at) break;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    len = '0; src_base = '0; dst_base = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, aborted, rd_en, wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000",
               {busy, done, aborted, rd_en, wr_en});
    end
    checks++;
    if ({sp_x, wr_data, rd_addr, wr_addr, clamp_cnt} !== 56'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0",
               {sp_x, wr_data, rd_addr, wr_addr, clamp_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0B17; exp_d[1] = 16'h1317; exp_d[2] = 16'h0317;
    mem[8'h10] = 16'h0000; mem[8'h11] = 16'h1000; mem[8'h12] = 16'hF000;
    run_job(8'd3, 8'h10, 8'h80, -1, -1, 40);
    checks++;
    if (wr_cyc.size() != 3) begin
      failures++;
      $display("FAIL basic_wr_count got=%0d want=3", wr_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_cyc[i] != 4 + 4 * i || wr_a[i] !== 8'(8'h80 + i) ||
            wr_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL basic_wr%0d got=c%0d a%h d%h want=c%0d a%h d%h", i,
                   wr_cyc[i], wr_a[i], wr_d[i], 4 + 4 * i, 8'h80 + i, exp_d[i]);
        end
      end
    end
    checks++;
    if (done_cyc != 13) begin
      failures++;
      $display("FAIL basic_done got=%0d want=13", done_cyc);
    end
    checks++;
    if (busy_first != 1 || busy_last != 13 || busy_n != 13) begin
      failures++;
      $display("FAIL basic_busy got=%0d..%0d n%0d want=1..13 n13",
               busy_first, busy_last, busy_n);
    end
    checks++;
    if (overlap != 0 || extra_done != 0 || abort_cyc_seen != -1) begin
      failures++;
      $display("FAIL basic_strobes got=ov%0d xd%0d ab%0d want=0 0 -1",
               overlap, extra_done, abort_cyc_seen);
    end
    checks++;
    if (sp_x !== 16'hF000 || wr_data !== 16'h0317) begin
      failures++;
      $display("FAIL basic_hold got=%h %h want=f000 0317", sp_x, wr_data);
    end
  endtask

  task automatic test_empty;
    run_job(8'd0, 8'h10, 8'h80, -1, -1, 20);
    checks++;
    if (done_cyc != 1 || busy_n != 1 || busy_first != 1) begin
      failures++;
      $display("FAIL empty_done got=d%0d b%0d want=d1 b1", done_cyc, busy_n);
    end
    checks++;
    if (rd_a.size() != 0 || wr_cyc.size() != 0) begin
      failures++;
      $display("FAIL empty_access got=rd%0d wr%0d want=0 0",
               rd_a.size(), wr_cyc.size());
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    run_job(8'd4, 8'hFE, 8'hF0, -1, -1, 40);
    checks++;
    if (rd_a.size() != 4 || done_cyc != 17) begin
      failures++;
      $display("FAIL wrap_count got=rd%0d d%0d want=4 17", rd_a.size(), done_cyc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_a[i] !== exp_a[i]) begin
          failures++;
          $display("FAIL wrap_rd%0d got=%h want=%h", i, rd_a[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_abort;
    run_job(8'd3, 8'h10, 8'h80, 6, -1, 40);
    checks++;
    if (wr_cyc.size() != 1 || wr_a[0] !== 8'h80) begin
      failures++;
      $display("FAIL abort_lat_wr got=%0d want=1 at 80", wr_cyc.size());
    end
    checks++;
    if (abort_cyc_seen != 7 || done_cyc != -1 || busy_last != 6) begin
      failures++;
      $display("FAIL abort_lat_pulse got=ab%0d d%0d bl%0d want=7 -1 6",
               abort_cyc_seen, done_cyc, busy_last);
    end
    run_job(8'd3, 8'h10, 8'h80, 4, -1, 40);
    checks++;
    if (wr_cyc.size() != 1 || abort_cyc_seen != 5 || done_cyc != -1) begin
      failures++;
      $display("FAIL abort_wr got=w%0d ab%0d d%0d want=1 5 -1",
               wr_cyc.size(), abort_cyc_seen, done_cyc);
    end
    run_job(8'd0, 8'h10, 8'h80, 1, -1, 20);
    checks++;
    if (done_cyc != 1 || abort_cyc_seen != -1) begin
      failures++;
      $display("FAIL abort_done got=d%0d ab%0d want=1 -1",
               done_cyc, abort_cyc_seen);
    end
    run_job(8'd1, 8'h11, 8'h84, 0, -1, 20);
    checks++;
    if (done_cyc != 5 || wr_cyc.size() != 1 || wr_d[0] !== 16'h1317 ||
        abort_cyc_seen != -1) begin
      failures++;
      $display("FAIL abort_with_start got=d%0d w%0d ab%0d want=5 1 -1",
               done_cyc, wr_cyc.size(), abort_cyc_seen);
    end
  endtask

  task automatic test_clamp;
    mem[8'h20] = 16'h0000; mem[8'h21] = 16'h7777; mem[8'h22] = 16'h1000;
    neg_on = 1'b1;
    run_job(8'd3, 8'h20, 8'h90, -1, -1, 40);
    neg_on = 1'b0;
    checks++;
    if (wr_cyc.size() != 3 || wr_d[0] !== 16'h0B17 || wr_d[1] !== 16'h0000 ||
        wr_d[2] !== 16'h1317) begin
      failures++;
      $display("FAIL clamp_data got=n%0d want=3 0b17 0000 1317", wr_cyc.size());
    end
    checks++;
    if (clamp_at_done !== 8'd1 || done_cyc != 13) begin
      failures++;
      $display("FAIL clamp_cnt got=%0d d%0d want=1 13", clamp_at_done, done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    run_job(8'd2, 8'h10, 8'hA0, -1, 3, 40);
    checks++;
    if (done_cyc != 9 || wr_cyc.size() != 2 || wr_a[1] !== 8'hA1 ||
        wr_d[1] !== 16'h1317 || clamp_at_done !== 8'd0 || rd_a.size() != 2) begin
      failures++;
      $display("FAIL restart_ignored got=d%0d w%0d cl%0d want=9 2 0",
               done_cyc, wr_cyc.size(), clamp_at_done);
    end
    @(posedge clk); #1;
    len = 8'd3; src_base = 8'h11; dst_base = 8'hB0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sp_x !== 16'h1000 || !busy) begin
      failures++;
      $display("FAIL rst_pre got=%h b%b want=1000 b1", sp_x, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, aborted, rd_en, wr_en} !== 5'b0 ||
        {sp_x, wr_data, rd_addr, wr_addr, clamp_cnt} !== 56'h0) begin
      failures++;
      $display("FAIL rst_async got=%b %h want=0",
               {busy, done, aborted, rd_en, wr_en},
               {sp_x, wr_data, rd_addr, wr_addr, clamp_cnt});
    end
    @(posedge clk); #1; rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || aborted || busy || rd_en || wr_en) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_quiet got=%0d want=0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset;
    test_basic;
    test_empty;
    test_wrap;
    test_abort;
    test_clamp;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
